out_frame_sequencer: RTL

//  Serial-to-parallel frame loader and display sequencer for the 15 LED/pad outputs (out1..out15).
//  - Receives a start-framed serial word on in1.
//  - Latches it onto the output bus and holds it for a dwell period.
//  - Then walks (rotates) the pattern a fixed number of steps and parks.
//  - Sits between the in1 input pad and the out*_FINAL_OUTPUT output buffers.

---
 rtl/outseq_pkg.sv | 29 ++
 rtl/outseq_sync.sv | 29 ++
 rtl/out_frame_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/outseq_pkg.sv
// Shared types and helpers for the output frame sequencer.
//   outseq_state_t   : FSM state encoding (IDLE, RECV, PAR, SHOW, ROTATE)
//   OUTSEQ_*_DEF     : default frame width and dwell length
//   f_cntw(max)      : bit width of a counter that must hold 0..max (minimum 1)
package outseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECV   = 3'd1,
        ST_PAR    = 3'd2,
        ST_SHOW   = 3'd3,
        ST_ROTATE = 3'd4
    } outseq_state_t;

    localparam int OUTSEQ_WIDTH_DEF = 15;
    localparam int OUTSEQ_DWELL_DEF = 16;

    // Equivalent to $clog2(max+1), but never returns 0 so a counter for a
    // zero maximum still has a legal one-bit declaration.
    function automatic int f_cntw(input int max);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= max) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/outseq_sync.sv
// Multi-flop synchronizer for the asynchronous serial input.
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset, clears the chain to 0
//   d_in   in   asynchronous input
//   q_out  out  synchronized output, STAGES cycles behind d_in
module outseq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d_in};

    // NOTE: flops use non-blocking assignment so every stage samples the
    // value from before the edge; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/out_frame_sequencer.sv
// Serial-to-parallel frame loader and display sequencer for the LED/pad bus.
// A start bit (1) on the synchronized input is followed by WIDTH data bits,
// LSB first. The frame is committed to out_bus, held for DWELL_CYCLES, then
// rotated left ROT_STEPS times every ROT_PERIOD cycles before parking.
// A start bit while displaying aborts the display and receives a new frame.
//   newCLK        in   clock, rising edge
//   global_reset  in   asynchronous active-low reset
//   in1           in   serial frame input (asynchronous)
//   out_bus       out  displayed pattern, bit0 -> out1
//   frame_valid   out  a frame has been committed since reset
//   busy          out  FSM not in IDLE
//   frame_err     out  one-cycle pulse on a parity-rejected frame
// Build option: define OUTSEQ_PARITY_EN to append an even-parity bit to
// every frame; otherwise frame_err is tied to 0.
module out_frame_sequencer
    import outseq_pkg::*;
#(
    parameter int WIDTH        = OUTSEQ_WIDTH_DEF,
    parameter int DWELL_CYCLES = OUTSEQ_DWELL_DEF,
    parameter int ROT_PERIOD   = 4,
    parameter int ROT_STEPS    = 15,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             newCLK,
    input  logic             global_reset,
    input  logic             in1,
    output logic [WIDTH-1:0] out_bus,
    output logic             frame_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int BIT_W   = f_cntw(WIDTH - 1);
    localparam int DWELL_W = f_cntw(DWELL_CYCLES - 1);
    localparam int PER_W   = f_cntw(ROT_PERIOD - 1);
    localparam int STEP_W  = f_cntw(ROT_STEPS);

    logic                s_in;
    outseq_state_t       state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [PER_W-1:0]    period_cnt_q, period_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [WIDTH-1:0]    shadow_q, shadow_d;
    logic [WIDTH-1:0]    out_bus_q, out_bus_d;
    logic                frame_valid_q, frame_valid_d;
    logic [WIDTH-1:0]    rot_val;
    logic                last_bit, dwell_done, period_done, last_step, commit;

    outseq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (newCLK),
        .rst_n (global_reset),
        .d_in  (in1),
        .q_out (s_in)
    );

    assign last_bit    = (int'(bit_cnt_q) == WIDTH - 1);
    assign dwell_done  = (int'(dwell_cnt_q) == DWELL_CYCLES - 1);
    assign period_done = (int'(period_cnt_q) == ROT_PERIOD - 1);
    assign last_step   = period_done && (int'(step_cnt_q) == ROT_STEPS - 1);

`ifdef OUTSEQ_PARITY_EN
    logic parity_ok;
    logic frame_err_q, frame_err_d;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_ok = ~(^{s_in, shadow_q});
    assign commit    = (state_q == ST_PAR) && parity_ok;

    always_comb frame_err_d = (state_q == ST_PAR) && !parity_ok;

    always_ff @(posedge newCLK or negedge global_reset) begin
        if (!global_reset) frame_err_q <= 1'b0;
        else               frame_err_q <= frame_err_d;
    end

    assign frame_err = frame_err_q;
`else
    // Without parity the frame commits on the same edge that samples its
    // last data bit.
    assign commit    = (state_q == ST_RECV) && last_bit;
    assign frame_err = 1'b0;
`endif

    // Left rotate by one; written bitwise so WIDTH=1 needs no special case.
    always_comb begin
        rot_val = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rot_val[i] = out_bus_q[(i + WIDTH - 1) % WIDTH];
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge newCLK or negedge global_reset) begin
        if (!global_reset) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path through the case can leave it unassigned (a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (s_in) state_d = ST_RECV;
            ST_RECV:   if (last_bit) state_d = commit ? ST_SHOW : ST_PAR;
            ST_PAR:    state_d = commit ? ST_SHOW : ST_IDLE;
            ST_SHOW: begin
                if (s_in)            state_d = ST_RECV;
                else if (dwell_done) state_d = (ROT_STEPS > 0) ? ST_ROTATE : ST_IDLE;
            end
            ST_ROTATE: begin
                if (s_in)           state_d = ST_RECV;
                else if (last_step) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath / output logic ----------------
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        dwell_cnt_d   = dwell_cnt_q;
        period_cnt_d  = period_cnt_q;
        step_cnt_d    = step_cnt_q;
        shadow_d      = shadow_q;
        out_bus_d     = out_bus_q;
        frame_valid_d = frame_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (s_in) bit_cnt_d = '0;
            end
            ST_RECV: begin
                // Bit n lands in shadow[n], i.e. LSB first.
                shadow_d[bit_cnt_q] = s_in;
                if (!last_bit) bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
            ST_SHOW: begin
                if (s_in) begin
                    bit_cnt_d = '0;
                end else if (dwell_done) begin
                    period_cnt_d = '0;
                    step_cnt_d   = '0;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            ST_ROTATE: begin
                // A start bit wins over a rotate step due on the same edge;
                // out_bus then keeps its current value until the next commit.
                if (s_in) begin
                    bit_cnt_d = '0;
                end else if (period_done) begin
                    out_bus_d    = rot_val;
                    period_cnt_d = '0;
                    if (int'(step_cnt_q) < ROT_STEPS) step_cnt_d = step_cnt_q + STEP_W'(1);
                end else begin
                    period_cnt_d = period_cnt_q + PER_W'(1);
                end
            end
            default: ;
        endcase

        // shadow_d already contains the bit sampled on this edge.
        if (commit) begin
            out_bus_d     = shadow_d;
            frame_valid_d = 1'b1;
            dwell_cnt_d   = '0;
        end
    end

    // NOTE: the shadow register is reset along with the counters so that a
    // frame cut short by reset can never surface on out_bus afterwards.
    always_ff @(posedge newCLK or negedge global_reset) begin
        if (!global_reset) begin
            bit_cnt_q     <= '0;
            dwell_cnt_q   <= '0;
            period_cnt_q  <= '0;
            step_cnt_q    <= '0;
            shadow_q      <= '0;
            out_bus_q     <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            dwell_cnt_q   <= dwell_cnt_d;
            period_cnt_q  <= period_cnt_d;
            step_cnt_q    <= step_cnt_d;
            shadow_q      <= shadow_d;
            out_bus_q     <= out_bus_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign out_bus     = out_bus_q;
    assign frame_valid = frame_valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
